// File: rtl/oled_pixel_sequencer.sv
// -----------------------------------------------------------------------------
// oled_pixel_sequencer
//
// Turns each rising edge of the divided slow_clock into a one-clk pixel strobe.
// Walks a raster address over a WIDTH x HEIGHT OLED panel. On each strobe it
// samples the colour from the upstream renderer and presents it as a registered
// pixel stream with a frame marker.
//
// Optional feature: define FRAME_COUNT_EN to add the frame_count output.
//
// Ports:
//   clk          100 MHz system clock (slow_clock is in the same domain)
//   rst_n        asynchronous active-low reset
//   slow_clock   divided clock, registered level in the clk domain
//   enable       run control; ticks are ignored while low
//   restart      synchronous pulse; returns the raster to pixel 0
//   pixel_data   colour for the current pixel_index (combinational upstream)
//   pixel_index  raster address, 0..WIDTH*HEIGHT-1
//   x, y         column / row of pixel_index
//   pixel_out    registered colour of the last sampled pixel
//   pixel_valid  one-clk pulse when pixel_out updates
//   frame_begin  one-clk pulse with pixel_valid when pixel_out holds pixel 0
//   frame_count  (FRAME_COUNT_EN only) completed frames, modulo 256
// -----------------------------------------------------------------------------
module oled_pixel_sequencer #(
    parameter int unsigned WIDTH      = 96,
    parameter int unsigned HEIGHT     = 64,
    parameter int unsigned COLOR_BITS = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  slow_clock,
    input  logic                  enable,
    input  logic                  restart,
    input  logic [COLOR_BITS-1:0] pixel_data,
    output logic [12:0]           pixel_index,
    output logic [6:0]            x,
    output logic [5:0]            y,
    output logic [COLOR_BITS-1:0] pixel_out,
    output logic                  pixel_valid,
`ifdef FRAME_COUNT_EN
    output logic [7:0]            frame_count,
`endif
    output logic                  frame_begin
);

    localparam logic [6:0] XMax = 7'(WIDTH - 1);
    localparam logic [5:0] YMax = 6'(HEIGHT - 1);

    logic                  prev_q;
    logic [12:0]           idx_q, idx_d;
    logic [6:0]            x_q, x_d;
    logic [5:0]            y_q, y_d;
    logic [COLOR_BITS-1:0] pix_q, pix_d;
    logic                  valid_q, valid_d;
    logic                  begin_q, begin_d;
    logic [7:0]            fcnt_q, fcnt_d;
    logic                  tick;
    logic                  advance;

    assign tick    = slow_clock & ~prev_q;
    assign advance = tick & enable & ~restart;

    always_comb begin
        idx_d   = idx_q;
        x_d     = x_q;
        y_d     = y_q;
        pix_d   = pix_q;
        valid_d = 1'b0;
        begin_d = 1'b0;
        fcnt_d  = fcnt_q;
        if (restart) begin
            // A tick coinciding with restart is dropped; pixel_out holds.
            idx_d  = '0;
            x_d    = '0;
            y_d    = '0;
            fcnt_d = '0;
        end else if (advance) begin
            pix_d   = pixel_data;
            valid_d = 1'b1;
            begin_d = (idx_q == 13'd0);
            if (x_q == XMax) begin
                x_d = '0;
                if (y_q == YMax) begin
                    y_d    = '0;
                    idx_d  = '0;
                    fcnt_d = fcnt_q + 8'd1;
                end else begin
                    y_d   = y_q + 6'd1;
                    idx_d = idx_q + 13'd1;
                end
            end else begin
                x_d   = x_q + 7'd1;
                idx_d = idx_q + 13'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // prev starts high so a slow_clock already high at release is not a tick.
            prev_q  <= 1'b1;
            idx_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            pix_q   <= '0;
            valid_q <= 1'b0;
            begin_q <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            prev_q  <= slow_clock;
            idx_q   <= idx_d;
            x_q     <= x_d;
            y_q     <= y_d;
            pix_q   <= pix_d;
            valid_q <= valid_d;
            begin_q <= begin_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign pixel_index = idx_q;
    assign x           = x_q;
    assign y           = y_q;
    assign pixel_out   = pix_q;
    assign pixel_valid = valid_q;
    assign frame_begin = begin_q;

`ifdef FRAME_COUNT_EN
    assign frame_count = fcnt_q;
`else
    logic unused_fcnt;
    assign unused_fcnt = ^fcnt_q;
`endif

endmodule
